// File: rtl/micro_sequencer_pkg.sv
// Shared types and constants for the micro-core fetch/execute sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package micro_sequencer_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  // opcode[3] marks a conditional branch; opcode[2:0] is then the condition.
  localparam int OP_BR_BIT = 3;

  // Branch condition codes (opcode[2:0] of a branch).
  localparam logic [2:0] BR_ALW  = 3'b000;
  localparam logic [2:0] BR_Z    = 3'b001;
  localparam logic [2:0] BR_NZ   = 3'b010;
  localparam logic [2:0] BR_N    = 3'b011;
  localparam logic [2:0] BR_C    = 3'b100;
  localparam logic [2:0] BR_V    = 3'b101;
  localparam logic [2:0] BR_RSVD = 3'b110;
  localparam logic [2:0] BR_HALT = 3'b111;

  // Bit positions inside the {N,Z,C,V} flag vector.
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/micro_sequencer_if.sv
// Instruction-fetch bus plus decoder/ALU side-band of the micro sequencer.
// Latency: n/a (wiring only).
// Backpressure: fetch side holds instr_req/pc until instr_valid arrives.
interface micro_sequencer_if #(
  parameter int PC_W = 8
);

  logic            instr_req;
  logic [PC_W-1:0] pc;
  logic            instr_valid;
  logic [PC_W+3:0] instr_data;
  logic            exec_en;
  logic [3:0]      opcode;
  logic [PC_W-1:0] operand;
  logic [1:0]      update_flags;
  logic [3:0]      alu_flags;
  logic [3:0]      flags;

  // Sequencer side.
  modport master (
    output instr_req, pc, exec_en, opcode, operand, flags,
    input  instr_valid, instr_data, update_flags, alu_flags
  );

  // Memory / decoder / ALU side.
  modport slave (
    input  instr_req, pc, exec_en, opcode, operand, flags,
    output instr_valid, instr_data, update_flags, alu_flags
  );

endinterface

// File: rtl/micro_sequencer_branch_cond.sv
// Branch-condition resolver: decides taken/halt from condition code and NZCV.
// Latency: purely combinational.
// Backpressure: none.
module micro_sequencer_branch_cond
  import micro_sequencer_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken,
  output logic       halt
);

  // Reserved code falls into the default arm and is simply not taken.
  always_comb begin
    taken = 1'b0;
    halt  = 1'b0;
    case (cond)
      BR_ALW:  taken = 1'b1;
      BR_Z:    taken = flags[FLG_Z];
      BR_NZ:   taken = ~flags[FLG_Z];
      BR_N:    taken = flags[FLG_N];
      BR_C:    taken = flags[FLG_C];
      BR_V:    taken = flags[FLG_V];
      BR_HALT: halt  = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Fetch/execute controller: PC, IR, NZCV flags, conditional branches; optional fetch timeout (UEC_SEQ_FETCH_TIMEOUT_EN).
// Latency: 2 cycles per instruction minimum (FETCH with immediate valid, then one EXEC cycle).
// Backpressure: FETCH waits indefinitely for instr_valid (bounded by FETCH_TIMEOUT when the macro is defined).
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
`ifdef UEC_SEQ_FETCH_TIMEOUT_EN
  ,
  parameter int FETCH_TIMEOUT = 15
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  micro_sequencer_if.master bus,
  output logic              busy,
  output logic              halted,
  output logic              fetch_err
);

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  seq_state_t      state, state_nxt;
  logic [PC_W-1:0] pc_q;
  logic [3:0]      ir_op;
  logic [PC_W-1:0] ir_opnd;
  logic [3:0]      flags_q;
  logic            br_taken;
  logic            br_halt;
  logic            is_branch;
  logic            start_go;
  logic            tmo_fire;
  logic [PC_W-1:0] pc_inc;

  assign is_branch = ir_op[OP_BR_BIT];
  assign start_go  = start && ((state == IDLE) || (state == HALT));
  assign pc_inc    = pc_q + PC_W'(1);

  micro_sequencer_branch_cond u_branch_cond (
    .cond  (ir_op[2:0]),
    .flags (flags_q),
    .taken (br_taken),
    .halt  (br_halt)
  );

`ifdef UEC_SEQ_FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // Wait-state counter: zero outside FETCH so every fetch starts fresh.
  always_ff @(posedge clk) begin
    if (rst || (state != FETCH)) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // A valid arriving in the last allowed cycle still completes the fetch.
  assign tmo_fire = (state == FETCH) && (wait_cnt == CNT_W'(FETCH_TIMEOUT - 1))
                    && !bus.instr_valid;

  // Sticky error, cleared only by reset or an accepted start.
  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      err_q <= 1'b0;
    end else if (tmo_fire) begin
      err_q <= 1'b1;
    end
  end

  assign fetch_err = err_q;
`else
  assign tmo_fire  = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only honoured from IDLE or HALT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HALT: if (start) state_nxt = FETCH;
      FETCH: begin
        if (bus.instr_valid) state_nxt = EXEC;
        else if (tmo_fire)   state_nxt = HALT;
      end
      EXEC: state_nxt = (is_branch && br_halt) ? HALT : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    bus.instr_req = (state == FETCH);
    bus.exec_en   = (state == EXEC);
    busy          = (state == FETCH) || (state == EXEC);
    halted        = (state == HALT);
  end

  // PC, IR and flag datapath; branches resolve on the flags held before EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RST_PC;
      ir_op   <= '0;
      ir_opnd <= '0;
      flags_q <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc_q    <= RST_PC;
            flags_q <= '0;
          end
        end
        FETCH: begin
          if (bus.instr_valid) begin
            ir_op   <= bus.instr_data[PC_W+3:PC_W];
            ir_opnd <= bus.instr_data[PC_W-1:0];
          end
        end
        EXEC: begin
          if (!is_branch) begin
            pc_q <= pc_inc;
            if (bus.update_flags[1]) begin
              flags_q[FLG_N] <= bus.alu_flags[FLG_N];
              flags_q[FLG_Z] <= bus.alu_flags[FLG_Z];
            end
            if (bus.update_flags[0]) begin
              flags_q[FLG_C] <= bus.alu_flags[FLG_C];
              flags_q[FLG_V] <= bus.alu_flags[FLG_V];
            end
          end else if (!br_halt) begin
            pc_q <= br_taken ? ir_opnd : pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pc      = pc_q;
  assign bus.opcode  = ir_op;
  assign bus.operand = ir_opnd;
  assign bus.flags   = flags_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: reset, straight-line program, wait states, branches, wrap, halt, reset mid-fetch.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: bench plays the instruction memory and controls instr_valid timing directly.
module tb_micro_sequencer;

  logic clk;
  logic rst;
  logic start;
  logic busy;
  logic halted;
  logic fetch_err;

  int vectors;
  int miscompares;

  micro_sequencer_if #(.PC_W(8)) bus ();

  micro_sequencer #(.PC_W(8), .RESET_PC(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .halted    (halted),
    .fetch_err (fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered in a FETCH cycle: serve one instruction, then drive decoder/ALU inputs during EXEC.
  task automatic run_instr(input logic [3:0] op, input logic [7:0] opnd,
                           input logic [1:0] uf, input logic [3:0] af);
    bus.instr_valid = 1'b1;
    bus.instr_data  = {op, opnd};
    tick(1);
    chk("exec_en_pulse", {31'd0, bus.exec_en}, 32'd1);
    chk("exec_opcode", {28'd0, bus.opcode}, {28'd0, op});
    bus.instr_valid  = 1'b0;
    bus.update_flags = uf;
    bus.alu_flags    = af;
    tick(1);
    bus.update_flags = 2'b00;
    bus.alu_flags    = 4'b0000;
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b1;
    start            = 1'b0;
    bus.instr_valid  = 1'b0;
    bus.instr_data   = '0;
    bus.update_flags = 2'b00;
    bus.alu_flags    = 4'b0000;

    tick(3);
    chk("rst_hold_req", {31'd0, bus.instr_req}, 32'd0);
    rst = 1'b0;
    tick(1);
    chk("rst_req",       {31'd0, bus.instr_req}, 32'd0);
    chk("rst_pc",        {24'd0, bus.pc},        32'h00);
    chk("rst_exec_en",   {31'd0, bus.exec_en},   32'd0);
    chk("rst_busy",      {31'd0, busy},          32'd0);
    chk("rst_halted",    {31'd0, halted},        32'd0);
    chk("rst_fetch_err", {31'd0, fetch_err},     32'd0);
    chk("rst_flags",     {28'd0, bus.flags},     32'h0);
    chk("rst_opcode",    {28'd0, bus.opcode},    32'h0);
    chk("rst_operand",   {24'd0, bus.operand},   32'h00);

    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("start_req",  {31'd0, bus.instr_req}, 32'd1);
    chk("start_pc",   {24'd0, bus.pc},        32'h00);
    chk("start_busy", {31'd0, busy},          32'd1);

    // ADD, SUB, NOP with zero wait states.
    run_instr(4'h1, 8'h11, 2'b11, 4'b1000);
    chk("add_pc",      {24'd0, bus.pc},        32'h01);
    chk("add_flags",   {28'd0, bus.flags},     32'h8);
    chk("add_exec_lo", {31'd0, bus.exec_en},   32'd0);
    chk("add_req",     {31'd0, bus.instr_req}, 32'd1);
    run_instr(4'h2, 8'h22, 2'b11, 4'b0110);
    chk("sub_pc",    {24'd0, bus.pc},    32'h02);
    chk("sub_flags", {28'd0, bus.flags}, 32'h6);
    run_instr(4'h0, 8'h00, 2'b00, 4'b1111);
    chk("nop_pc",    {24'd0, bus.pc},    32'h03);
    chk("nop_flags", {28'd0, bus.flags}, 32'h6);
    run_instr(4'h0, 8'h00, 2'b00, 4'b0000);
    run_instr(4'h0, 8'h00, 2'b00, 4'b0000);
    chk("pre_wait_pc", {24'd0, bus.pc}, 32'h05);

    // Four wait states at pc=5, valid on the fifth FETCH cycle.
    for (int i = 0; i < 4; i++) begin
      chk("wait_req",  {31'd0, bus.instr_req}, 32'd1);
      chk("wait_pc",   {24'd0, bus.pc},        32'h05);
      chk("wait_exec", {31'd0, bus.exec_en},   32'd0);
      tick(1);
    end
    chk("wait5_req", {31'd0, bus.instr_req}, 32'd1);
    chk("wait5_pc",  {24'd0, bus.pc},        32'h05);

    // BZ 0x20 with Z=1; spurious valid during EXEC; branch ignores flag update.
    bus.instr_valid = 1'b1;
    bus.instr_data  = {4'b1001, 8'h20};
    tick(1);
    chk("bz_exec",   {31'd0, bus.exec_en}, 32'd1);
    chk("bz_opcode", {28'd0, bus.opcode},  32'h9);
    bus.instr_data   = {4'h0, 8'hAB};
    bus.update_flags = 2'b11;
    bus.alu_flags    = 4'b0000;
    tick(1);
    bus.instr_valid  = 1'b0;
    bus.update_flags = 2'b00;
    chk("bz_taken_pc",   {24'd0, bus.pc},        32'h20);
    chk("bz_flags_kept", {28'd0, bus.flags},     32'h6);
    chk("bz_one_exec",   {31'd0, bus.exec_en},   32'd0);
    chk("spur_opcode",   {28'd0, bus.opcode},    32'h9);
    chk("spur_operand",  {24'd0, bus.operand},   32'h20);
    chk("bz_req",        {31'd0, bus.instr_req}, 32'd1);

    // Partial flag updates and the remaining branch conditions.
    run_instr(4'h3, 8'h00, 2'b10, 4'b1000);
    chk("nz_only_flags", {28'd0, bus.flags}, 32'hA);
    run_instr(4'b1001, 8'h40, 2'b00, 4'b0000);
    chk("bz_nt_pc",    {24'd0, bus.pc},    32'h22);
    chk("bz_nt_flags", {28'd0, bus.flags}, 32'hA);
    run_instr(4'b1011, 8'h50, 2'b00, 4'b0000);
    chk("bn_pc", {24'd0, bus.pc}, 32'h50);
    run_instr(4'h4, 8'h00, 2'b01, 4'b0101);
    chk("cv_only_flags", {28'd0, bus.flags}, 32'h9);
    chk("cv_pc",         {24'd0, bus.pc},    32'h51);
    run_instr(4'b1110, 8'h77, 2'b00, 4'b0000);
    chk("rsvd_pc", {24'd0, bus.pc}, 32'h52);
    run_instr(4'b1100, 8'h60, 2'b00, 4'b0000);
    chk("bc_nt_pc", {24'd0, bus.pc}, 32'h53);
    run_instr(4'b1101, 8'hFF, 2'b00, 4'b0000);
    chk("bv_pc", {24'd0, bus.pc}, 32'hFF);
    run_instr(4'h1, 8'h00, 2'b00, 4'b0000);
    chk("wrap_pc", {24'd0, bus.pc}, 32'h00);
    run_instr(4'b1010, 8'h30, 2'b00, 4'b0000);
    chk("bnz_pc", {24'd0, bus.pc}, 32'h30);
    run_instr(4'b1000, 8'h80, 2'b00, 4'b0000);
    chk("balw_pc", {24'd0, bus.pc}, 32'h80);

    // HALT.
    run_instr(4'b1111, 8'h12, 2'b11, 4'b0000);
    chk("halt_halted", {31'd0, halted},        32'd1);
    chk("halt_busy",   {31'd0, busy},          32'd0);
    chk("halt_req",    {31'd0, bus.instr_req}, 32'd0);
    chk("halt_pc",     {24'd0, bus.pc},        32'h80);
    chk("halt_flags",  {28'd0, bus.flags},     32'h9);
    tick(1);
    chk("halt_hold_pc",     {24'd0, bus.pc}, 32'h80);
    chk("halt_hold_halted", {31'd0, halted}, 32'd1);

    // Restart from HALT.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("restart_pc",     {24'd0, bus.pc},        32'h00);
    chk("restart_flags",  {28'd0, bus.flags},     32'h0);
    chk("restart_req",    {31'd0, bus.instr_req}, 32'd1);
    chk("restart_halted", {31'd0, halted},        32'd0);

    // Reset mid-FETCH with a pending valid.
    rst             = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr_data  = {4'h5, 8'h55};
    tick(1);
    chk("midrst_req",    {31'd0, bus.instr_req}, 32'd0);
    chk("midrst_pc",     {24'd0, bus.pc},        32'h00);
    chk("midrst_opcode", {28'd0, bus.opcode},    32'h0);
    chk("midrst_busy",   {31'd0, busy},          32'd0);
    rst             = 1'b0;
    tick(1);
    bus.instr_valid = 1'b0;
    chk("post_rst_req",    {31'd0, bus.instr_req}, 32'd0);
    chk("post_rst_exec",   {31'd0, bus.exec_en},   32'd0);
    chk("post_rst_opcode", {28'd0, bus.opcode},    32'h0);

`ifdef UEC_SEQ_FETCH_TIMEOUT_EN
    // Fetch never answered: 15 FETCH cycles, then HALT with fetch_err.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("tmo_req_first", {31'd0, bus.instr_req}, 32'd1);
    tick(14);
    chk("tmo_req_last", {31'd0, bus.instr_req}, 32'd1);
    chk("tmo_not_yet",  {31'd0, halted},        32'd0);
    tick(1);
    chk("tmo_halted", {31'd0, halted},        32'd1);
    chk("tmo_err",    {31'd0, fetch_err},     32'd1);
    chk("tmo_req",    {31'd0, bus.instr_req}, 32'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("tmo_err_clr", {31'd0, fetch_err}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
Fetch/execute controller for the 4-bit-opcode micro core. It fetches instructions over a request/valid handshake and holds the program counter. It drives the decoder enable and opcode for exactly one execute cycle per instruction. It owns the NZCV flag register and resolves conditional branches, i.e. opcodes with bit 3 set.

Parameters:
PC_W, 8, program counter / branch target width; instruction word = {opcode[3:0], operand[PC_W-1:0]}
RESET_PC, 0, PC value loaded on reset and on start

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin execution from RESET_PC; honoured only in IDLE or HALT
instr_req  out  1  fetch request; held high with stable pc until instr_valid
pc  out  PC_W  fetch address
instr_valid  in  1  instr_data valid this cycle; ignored while instr_req=0
instr_data  in  4+PC_W  fetched instruction
exec_en  out  1  decoder enable, high for one cycle per executed instruction
opcode  out  4  IR opcode, drives decoder OPcode
operand  out  PC_W  IR operand
update_flags  in  2  from decoder: [1] update N,Z; [0] update C,V
alu_flags  in  4  {N,Z,C,V} produced by ALU in the exec cycle
flags  out  4  registered {N,Z,C,V}
busy  out  1  high in FETCH and EXEC
halted  out  1  high in HALT
fetch_err  out  1  sticky fetch-timeout error (tied 0 without macro)

Behaviour:
- States: IDLE, FETCH, EXEC, HALT. Encoding comes from the package enum.
- Reset values: state=IDLE, pc=RESET_PC, IR=0, flags=0, instr_req=0, exec_en=0, busy=0, halted=0, fetch_err=0.
- Reset mid-fetch or mid-exec: all registers return to reset values on that edge. instr_req drops the next cycle. A pending instr_valid is discarded.
- IDLE/HALT, start=1: pc<=RESET_PC, flags<=0, go to FETCH. start in FETCH/EXEC is ignored.
- FETCH: instr_req=1, pc stable. On the edge where instr_valid=1, IR<=instr_data and state goes to EXEC. There is no limit on wait states without the macro.
- EXEC (one cycle): exec_en=1; opcode/operand come from IR.
- EXEC, flag update at the end-of-cycle edge: N,Z<=alu_flags[3:2] if update_flags[1]; C,V<=alu_flags[1:0] if update_flags[0].
- EXEC, opcode[3]=0: pc<=pc+1, modulo 2^PC_W (all-ones wraps to 0), next state FETCH.
- EXEC, opcode[3]=1 (branch): condition opcode[2:0] is evaluated on flags as registered before this EXEC. Branches never change flags.
  - 000 always, 001 Z, 010 !Z, 011 N, 100 C, 101 V.
  - Taken: pc<=operand. Not taken: pc<=pc+1.
  - 110 reserved: behaves as not-taken.
  - 111 HALT: pc unchanged, next state HALT.
- Minimum throughput: 2 cycles per instruction (FETCH with immediate valid, then EXEC).
- opcode/operand outputs hold the IR value in every state.

Optional Feature:
UEC_SEQ_FETCH_TIMEOUT_EN
- With the macro: parameter FETCH_TIMEOUT (default 15) is present, and a wait counter runs in FETCH. After FETCH_TIMEOUT cycles without instr_valid: instr_req drops, fetch_err<=1, state goes to HALT.
  - The counter clears on entering FETCH.
  - fetch_err clears only on rst or start.
  - instr_valid arriving in the timeout cycle itself wins and the fetch completes normally.
- Without the macro: no counter, fetch_err tied 0.

Decomposition:
- commands_pkg: add seq_state_t enum (IDLE, FETCH, EXEC, HALT), branch-condition constants BR_ALW, BR_Z, BR_NZ, BR_N, BR_C, BR_V, BR_HALT, and flag bit index constants FLG_N/Z/C/V.
- One sub-module: branch_cond, combinational (cond[2:0], flags[3:0] -> taken, halt).

Test Plan:
- rst held 3 cycles, then released -> all outputs at reset values. start=1 -> next cycle instr_req=1, pc=0.
- Program ADD, SUB, NOP fetched with 0 wait states -> exec_en pulses every 2nd cycle, pc 0,1,2,3. flags update only on ADD/SUB per update_flags=2'b11 and alu_flags.
- instr_valid delayed 4 cycles at pc=5 -> pc/instr_req stable for 5 cycles, exactly one exec_en. A spurious instr_valid with instr_req=0 is ignored.
- flags Z=1, instr 4'b1001 operand 8'h20 -> pc=8'h20. Same with Z=0 -> pc=pc+1. Branch with update_flags=0 -> flags unchanged.
- PC_W=8, pc=8'hFF executing ADD -> next fetch pc=8'h00. Instr 4'b1111 -> halted=1, busy=0, pc held. start -> pc=0, flags=0.
- Macro on, FETCH_TIMEOUT=15, instr_valid never asserted -> after 15 cycles halted=1, fetch_err=1. rst asserted mid-FETCH -> instr_req=0 the following cycle.
